// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    // Receive FSM states: wait for start bit, shift data, capture parity, check stop.
    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_rx_state;

    // Bit positions inside the status byte presented to the CPU.
    localparam int unsigned STAT_VALID      = 0;
    localparam int unsigned STAT_PARITY_ERR = 1;
    localparam int unsigned STAT_FRAME_ERR  = 2;
    localparam int unsigned STAT_OVERRUN    = 3;

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// CPU-facing port-register link: scancode and status out to the adapter, ack back.
interface ps2_keyboard_rx_if;

    logic [7:0] scancode;
    logic [7:0] status;
    logic       ack;

    // Receiver side drives the holding register, CPU side returns the acknowledge.
    modport master (
        output scancode,
        output status,
        input  ack
    );

    modport slave (
        input  scancode,
        input  status,
        output ack
    );

endinterface

// File: rtl/ps2_line_filter.sv
// Synchronizer plus consecutive-sample glitch filter for the PS/2 clock line,
// producing a one-cycle pulse on each filtered 1->0 transition.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic fall
);

    localparam int unsigned CntW = $clog2(FILTER_LEN + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(FILTER_LEN - 1);

    logic [1:0]      sync_q;
    logic            filt_q;
    logic            filt_d;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            fall_q;

    // Count how long the synchronized level has disagreed with the filtered one.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CntLast) begin
                filt_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Line idles high, so synchronizer and filter reset high to avoid a false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            cnt_q  <= '0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], line};
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
            fall_q <= filt_q & ~filt_d;
        end
    end

    assign fall = fall_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: decodes device-to-host frames into a scancode holding
// register with valid/error status, cleared by a rising edge on ack.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    ps2_keyboard_rx_if.master bus
);

    localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ToW-1:0] ToMax = ToW'(TIMEOUT_CYCLES);

    logic        clk_fall;
    logic [1:0]  data_sync_q;
    logic        data_bit;

    ps2_rx_state state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           parity_q, parity_d;
    logic [ToW-1:0] to_cnt_q, to_cnt_d;

    logic       good_ev, parity_err_ev, frame_err_ev;
    logic       ack_q, ack_rise;
    logic [7:0] scancode_q, scancode_d;
    logic       valid_q, valid_d;
    logic       parity_err_q, parity_err_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk   (clk),
        .reset (reset),
        .line  (ps2_clk),
        .fall  (clk_fall)
    );

    assign data_bit = data_sync_q[1];
    assign ack_rise = bus.ack & ~ack_q;

    // Frame FSM next state, including inter-edge timeout while mid-frame.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        parity_d      = parity_q;
        to_cnt_d      = '0;
        good_ev       = 1'b0;
        parity_err_ev = 1'b0;
        frame_err_ev  = 1'b0;

        if (state_q != IDLE && to_cnt_q == ToMax) begin
            // Device stalled mid-frame: abandon the partial byte.
            state_d      = IDLE;
            frame_err_ev = 1'b1;
        end else begin
            if (state_q != IDLE && !clk_fall) begin
                to_cnt_d = to_cnt_q + ToW'(1);
            end
            unique case (state_q)
                IDLE: begin
                    if (clk_fall && !data_bit) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                DATA: begin
                    if (clk_fall) begin
                        shreg_d   = {data_bit, shreg_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (clk_fall) begin
                        parity_d = data_bit;
                        state_d  = STOP;
                    end
                end
                STOP: begin
                    if (clk_fall) begin
                        state_d = IDLE;
                        if (!data_bit) begin
                            frame_err_ev = 1'b1;
                        end else if (!(^{shreg_q, parity_q})) begin
                            parity_err_ev = 1'b1;
                        end else begin
                            good_ev = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Holding register update: ack clears first, then frame events set bits.
    always_comb begin
        scancode_d   = scancode_q;
        valid_d      = valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;

        if (ack_rise) begin
            valid_d      = 1'b0;
            parity_err_d = 1'b0;
            frame_err_d  = 1'b0;
            overrun_d    = 1'b0;
        end
        if (good_ev) begin
            // A byte still held unacknowledged is kept; the new one is dropped.
            if (valid_q && !ack_rise) begin
                overrun_d = 1'b1;
            end else begin
                scancode_d = shreg_q;
                valid_d    = 1'b1;
            end
        end
        if (parity_err_ev) begin
            parity_err_d = 1'b1;
        end
        if (frame_err_ev) begin
            frame_err_d = 1'b1;
        end
    end

    // State registers for the data synchronizer, FSM and holding register.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_sync_q  <= 2'b11;
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shreg_q      <= 8'h00;
            parity_q     <= 1'b0;
            to_cnt_q     <= '0;
            ack_q        <= 1'b0;
            scancode_q   <= 8'h00;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            data_sync_q  <= {data_sync_q[0], ps2_data};
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            parity_q     <= parity_d;
            to_cnt_q     <= to_cnt_d;
            ack_q        <= bus.ack;
            scancode_q   <= scancode_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    // Pack status flags into the CPU-visible byte.
    always_comb begin
        bus.status                  = 8'h00;
        bus.status[STAT_VALID]      = valid_q;
        bus.status[STAT_PARITY_ERR] = parity_err_q;
        bus.status[STAT_FRAME_ERR]  = frame_err_q;
        bus.status[STAT_OVERRUN]    = overrun_q;
    end

    assign bus.scancode = scancode_q;

endmodule
